// File: rtl/hamming_secded_pipe_if.sv
// Stream bundle for hamming_secded_pipe: data word and channel error mask in, decoded word and status out.
// Carries no state of its own, so it adds no latency.
// Backpressure: out_ready from master, in_ready back from slave; master = word source/sink, slave = codec.
interface hamming_secded_pipe_if #(
    parameter int DATA_W = 16
);
    localparam int PAR_W  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6;
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [CODE_W-1:0] bit_flip;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [PAR_W-1:0]  syndrome;
    logic              err_corr;
    logic              err_uncorr;

    modport master (
        output in_valid, data_in, bit_flip, out_ready,
        input  in_ready, out_valid, data_out, syndrome, err_corr, err_uncorr
    );

    modport slave (
        input  in_valid, data_in, bit_flip, out_ready,
        output in_ready, out_valid, data_out, syndrome, err_corr, err_uncorr
    );
endinterface

// File: rtl/hamming_secded_pipe.sv
// Hamming SECDED encode -> bit_flip channel -> correct/detect decode; counters built only with HAMMING_ERR_STATS_EN.
// Latency: 2 cycles from input handshake to out_valid, 1 word/cycle.
// Backpressure: out_ready low freezes both stages; in_ready is combinational from out_ready.
module hamming_secded_pipe #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_secded_pipe_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);
    localparam int PAR_W  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6;
    localparam int CODE_W = DATA_W + PAR_W + 1;
    localparam int CW_IW  = $clog2(CODE_W);
    localparam int D_IW   = $clog2(DATA_W);
    localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CODE_W - 1);

    // Data fills non-power-of-two positions in ascending order; position i lives in bit i-1.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] cw;
        logic              p;
        int                j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[CW_IW'(pos - 1)] = d[D_IW'(j)];
                j++;
            end
        end
        for (int k = 0; k < PAR_W; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < CODE_W; pos++) begin
                if (((pos >> k) & 1) != 0) p = p ^ cw[CW_IW'(pos - 1)];
            end
            cw[CW_IW'((1 << k) - 1)] = p;
        end
        cw[CODE_W-1] = ^cw[CODE_W-2:0];
        return cw;
    endfunction

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic              s1_adv;
    logic              s2_adv;

    logic [CODE_W-1:0] rx_code;
    logic [CODE_W-1:0] fixed_code;
    logic [PAR_W-1:0]  rx_syn;
    logic              rx_q;
    logic              dec_corr;
    logic              dec_uncorr;
    logic [DATA_W-1:0] dec_data;

    assign s2_adv       = !bus.out_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // bit_flip is applied unregistered on the stage-1 -> stage-2 path.
    always_comb begin
        int j;
        rx_code    = s1_code ^ bus.bit_flip;
        rx_syn     = '0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if (rx_code[CW_IW'(pos - 1)]) rx_syn = rx_syn ^ PAR_W'(pos);
        end
        rx_q       = ^rx_code;
        dec_corr   = rx_q && (rx_syn <= MAX_POS);
        dec_uncorr = (!rx_q && (rx_syn != '0)) || (rx_q && (rx_syn > MAX_POS));
        fixed_code = rx_code;
        if (rx_q && (rx_syn != '0) && (rx_syn <= MAX_POS)) begin
            fixed_code[CW_IW'(rx_syn - 1'b1)] = ~rx_code[CW_IW'(rx_syn - 1'b1)];
        end
        dec_data = '0;
        j        = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                dec_data[D_IW'(j)] = fixed_code[CW_IW'(pos - 1)];
                j++;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_code        <= '0;
            bus.out_valid  <= 1'b0;
            bus.data_out   <= '0;
            bus.syndrome   <= '0;
            bus.err_corr   <= 1'b0;
            bus.err_uncorr <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) s1_code <= encode(bus.data_in);
            end
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.data_out   <= dec_data;
                    bus.syndrome   <= rx_syn;
                    bus.err_corr   <= dec_corr;
                    bus.err_uncorr <= dec_uncorr;
                end
            end
        end
    end

`ifdef HAMMING_ERR_STATS_EN
    logic out_hs;
    assign out_hs = bus.out_valid && bus.out_ready;

    // Clear has priority over a same-cycle increment; both counters saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (out_hs && bus.err_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_hs && bus.err_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif
endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed bench for hamming_secded_pipe (DATA_W=16, CNT_W=2); counter expectations follow HAMMING_ERR_STATS_EN.
module tb_hamming_secded_pipe;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 2;
`ifdef HAMMING_ERR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;
    int               checks = 0;
    int               failures = 0;

    hamming_secded_pipe_if #(.DATA_W(DATA_W)) bus ();

    hamming_secded_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    // data, channel mask, expected data, syndrome, {err_corr, err_uncorr}
    localparam logic [15:0] V_DATA [7] = '{16'hA5A5, 16'h0001, 16'h1234, 16'h1234, 16'h0000, 16'hFFFF, 16'h5A5A};
    localparam logic [21:0] V_FLIP [7] = '{22'h000000, 22'h000004, 22'h100000, 22'h000003, 22'h000014, 22'h200000, 22'h208080};
    localparam logic [15:0] V_EXP  [7] = '{16'hA5A5, 16'h0001, 16'h1234, 16'h1234, 16'h0003, 16'hFFFF, 16'h5A5A};
    localparam logic [4:0]  V_SYN  [7] = '{5'd0, 5'd3, 5'd21, 5'd3, 5'd6, 5'd0, 5'd24};
    localparam logic [1:0]  V_FLG  [7] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};

    task automatic run_word(input logic [15:0] d, input logic [21:0] f, output bit got, output int lat);
        bus.data_in   = d;
        bus.bit_flip  = f;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                got = 1'b1;
                lat = i + 2;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if ({bus.data_out, bus.syndrome, bus.err_corr, bus.err_uncorr} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs data=%h syn=%0d corr=%b unc=%b exp all 0", bus.data_out, bus.syndrome, bus.err_corr, bus.err_uncorr);
        end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== 4'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", corr_cnt, uncorr_cnt); end
    endtask

    task automatic test_decode();
        bit got;
        int lat;
        int ec = 0;
        int eu = 0;
        for (int v = 0; v < 7; v++) begin
            run_word(V_DATA[v], V_FLIP[v], got, lat);
            checks++;
            if (!got || lat != 2) begin failures++; $display("FAIL decode[%0d]_latency got=%0d seen=%b exp=2", v, lat, got); end
            checks++;
            if (bus.data_out !== V_EXP[v]) begin failures++; $display("FAIL decode[%0d]_data got=%h exp=%h", v, bus.data_out, V_EXP[v]); end
            checks++;
            if (bus.syndrome !== V_SYN[v]) begin failures++; $display("FAIL decode[%0d]_syndrome got=%0d exp=%0d", v, bus.syndrome, V_SYN[v]); end
            checks++;
            if ({bus.err_corr, bus.err_uncorr} !== V_FLG[v]) begin
                failures++;
                $display("FAIL decode[%0d]_flags got=%b%b exp=%b", v, bus.err_corr, bus.err_uncorr, V_FLG[v]);
            end
            @(posedge clk); #1;
            ec = (STATS && V_FLG[v][1] && ec < 3) ? ec + 1 : ec;
            eu = (STATS && V_FLG[v][0] && eu < 3) ? eu + 1 : eu;
            checks++;
            if (corr_cnt !== CNT_W'(ec) || uncorr_cnt !== CNT_W'(eu)) begin
                failures++;
                $display("FAIL decode[%0d]_counters got=%0d/%0d exp=%0d/%0d", v, corr_cnt, uncorr_cnt, ec, eu);
            end
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL decode[%0d]_no_repeat out_valid=%b exp=0", v, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcvd = 0;
        bit saw_stall = 1'b0;
        for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            bus.in_valid  = (sent < 8);
            bus.data_in   = 16'(sent + 1);
            bus.bit_flip  = '0;
            #1;
            if (!bus.in_ready) saw_stall = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if ({bus.data_out, bus.err_corr, bus.err_uncorr} !== {16'(rcvd + 1), 2'b00}) begin
                    failures++;
                    $display("FAIL stream_word[%0d] got=%h flags=%b%b exp=%h flags=00", rcvd, bus.data_out, bus.err_corr, bus.err_uncorr, 16'(rcvd + 1));
                end
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (rcvd != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", rcvd); end
        checks++;
        if (!saw_stall) begin failures++; $display("FAIL stream_in_ready_drop got=0 exp=1"); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained out_valid=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_in_flight();
        bit delivered = 1'b0;
        bus.out_ready = 1'b1;
        bus.bit_flip  = 22'h000004;
        bus.in_valid  = 1'b1;
        bus.data_in   = 16'h00AA;
        @(posedge clk); #1;
        bus.data_in = 16'h00BB;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flight_loaded out_valid=%b exp=1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flight_async_clear out_valid=%b exp=0", bus.out_valid); end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== 4'd0) begin failures++; $display("FAIL flight_counters got=%0d/%0d exp=0/0", corr_cnt, uncorr_cnt); end
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) delivered = 1'b1;
        end
        checks++;
        if (delivered) begin failures++; $display("FAIL flight_no_delivery got=1 exp=0"); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flight_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_counter_sat();
        bit got;
        int lat;
        int ec = 0;
        for (int n = 0; n < 8; n++) begin
            run_word(16'(n * 3 + 1), 22'h000004, got, lat);
            checks++;
            if (!got) begin failures++; $display("FAIL sat[%0d]_delivered got=0 exp=1", n); end
            cnt_clr = (n == 2);
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            ec = (n == 2) ? 0 : ((STATS && ec < 3) ? ec + 1 : ec);
            checks++;
            if (corr_cnt !== CNT_W'(ec)) begin failures++; $display("FAIL sat[%0d]_corr_cnt got=%0d exp=%0d", n, corr_cnt, ec); end
        end
        checks++;
        if (uncorr_cnt !== 2'd0) begin failures++; $display("FAIL sat_uncorr_cnt got=%0d exp=0", uncorr_cnt); end
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        checks++;
        if (corr_cnt !== 2'd0) begin failures++; $display("FAIL sat_clear got=%0d exp=0", corr_cnt); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.bit_flip  = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_decode();
        test_back_to_back();
        test_reset_in_flight();
        test_counter_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
